// File: rtl/hw_info_scanner_if.sv
// Word-addressed register bus between the hardware-info scanner (initiator)
// and the board register block (responder).
interface hw_info_scanner_if;
  logic [4:1]  vme_addr_o;
  logic        vme_rd_mem_o;
  logic        vme_wr_mem_o;
  logic [15:0] vme_wr_data_o;
  logic [15:0] vme_rd_data_i;
  logic        vme_rd_done_i;
  logic        vme_wr_done_i;

  modport master (
    output vme_addr_o, vme_rd_mem_o, vme_wr_mem_o, vme_wr_data_o,
    input  vme_rd_data_i, vme_rd_done_i, vme_wr_done_i
  );

  modport slave (
    input  vme_addr_o, vme_rd_mem_o, vme_wr_mem_o, vme_wr_data_o,
    output vme_rd_data_i, vme_rd_done_i, vme_wr_done_i
  );
endinterface

// File: rtl/hw_info_scanner.sv
// Reads the board identification words over the register bus, checks the
// standard version and an echo register, and holds the decoded fields.
module hw_info_scanner #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [7:0]  EXPECTED_STD = 8'h01,
  parameter logic [7:0]  ECHO_PATTERN = 8'hA5,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  hw_info_scanner_if.master  vme,
  output logic [31:0]        std_version_o,
  output logic [63:0]        serial_number_o,
  output logic [23:0]        fw_version_o,
  output logic [23:0]        mm_version_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               valid_o,
  output logic [1:0]         err_code_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FINISH} state_t;

  localparam int            CW        = $clog2(TIMEOUT + 1);
  // cnt_r lags the elapsed-cycle count by one, so the last WAIT cycle sees TIMEOUT-2
  localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT - 2);
  localparam logic [3:0]    IDX_WRITE = 4'd10;
  localparam logic [3:0]    IDX_LAST  = 4'd11;

  state_t          state_r;
  state_t          next_state_s;
  logic [3:0]      idx_r;
  logic [CW-1:0]   cnt_r;
  logic [15:0]     word_r [0:9];
  logic [7:0]      echo_r;
  logic            valid_r;
  logic [1:0]      err_r;
  logic            auto_r;
  logic            start_s;
  logic            is_write_s;
  logic            accept_s;
  logic            std_bad_s;
  logic            timeout_s;
  logic            unused_hi_s;

  assign start_s    = start_i | auto_r;
  assign is_write_s = (idx_r == IDX_WRITE);
  assign accept_s   = (state_r == S_WAIT) &&
                      (is_write_s ? vme.vme_wr_done_i : vme.vme_rd_done_i);
  assign std_bad_s  = (idx_r == 4'd0) && (vme.vme_rd_data_i[7:0] != EXPECTED_STD);
  assign timeout_s  = (cnt_r == TO_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) next_state_s = S_ISSUE;
        else         next_state_s = S_IDLE;
      end
      S_ISSUE: next_state_s = S_WAIT;
      S_WAIT: begin
        if (accept_s) begin
          if (std_bad_s)              next_state_s = S_FINISH;
          else if (idx_r == IDX_LAST) next_state_s = S_CHECK;
          else                        next_state_s = S_ISSUE;
        end else if (timeout_s) begin
          next_state_s = S_FINISH;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_CHECK:  next_state_s = S_FINISH;
      S_FINISH: next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    vme.vme_rd_mem_o = 1'b0;
    vme.vme_wr_mem_o = 1'b0;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    case (state_r)
      S_IDLE: busy_o = 1'b0;
      S_ISSUE: begin
        busy_o = 1'b1;
        if (is_write_s) vme.vme_wr_mem_o = 1'b1;
        else            vme.vme_rd_mem_o = 1'b1;
      end
      S_WAIT, S_CHECK: busy_o = 1'b1;
      S_FINISH: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

  // Address and write data follow the transaction index, which only moves on an accepted done
  assign vme.vme_addr_o    = (idx_r >= IDX_WRITE) ? 4'hB : idx_r;
  assign vme.vme_wr_data_o = is_write_s ? {8'h00, ECHO_PATTERN} : 16'h0000;

  // Transaction index, timeout counter, captured words and status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_r  <= AUTO_START;
      idx_r   <= 4'd0;
      cnt_r   <= '0;
      echo_r  <= 8'h00;
      valid_r <= 1'b0;
      err_r   <= 2'b00;
      for (int i = 0; i < 10; i++) word_r[i] <= 16'h0000;
    end else begin
      auto_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            idx_r   <= 4'd0;
            valid_r <= 1'b0;
            err_r   <= 2'b00;
          end
        end
        S_ISSUE: cnt_r <= '0;
        S_WAIT: begin
          cnt_r <= cnt_r + 1'b1;
          if (accept_s) begin
            if (idx_r < IDX_WRITE)      word_r[idx_r] <= vme.vme_rd_data_i;
            else if (idx_r == IDX_LAST) echo_r <= vme.vme_rd_data_i[7:0];
            if (std_bad_s)              err_r <= 2'b10;
            else if (idx_r != IDX_LAST) idx_r <= idx_r + 4'd1;
          end else if (timeout_s) begin
            err_r <= 2'b01;
          end
        end
        S_CHECK:  err_r   <= (echo_r != ECHO_PATTERN) ? 2'b11 : 2'b00;
        S_FINISH: valid_r <= (err_r == 2'b00);
        default:  idx_r   <= idx_r;
      endcase
    end
  end

  assign std_version_o   = {word_r[0], word_r[1]};
  assign serial_number_o = {word_r[2], word_r[3], word_r[4], word_r[5]};
  assign fw_version_o    = {word_r[6][7:0], word_r[7]};
  assign mm_version_o    = {word_r[8][7:0], word_r[9]};
  assign valid_o         = valid_r;
  assign err_code_o      = err_r;
  assign unused_hi_s     = ^{word_r[6][15:8], word_r[8][15:8]};

endmodule

// File: tb/tb_hw_info_scanner.sv
// Directed bench: a one-cycle-latency register responder with fault options,
// a bus monitor, and a linear sequence of scans checked with immediate assertions.
module tb_hw_info_scanner;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] std_version_o;
  logic [63:0] serial_number_o;
  logic [23:0] fw_version_o;
  logic [23:0] mm_version_o;
  logic        busy_o, done_o, valid_o;
  logic [1:0]  err_code_o;

  hw_info_scanner_if bus();

  hw_info_scanner #(.TIMEOUT(TIMEOUT), .EXPECTED_STD(8'h01), .ECHO_PATTERN(8'hA5), .AUTO_START(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .vme(bus.master),
    .std_version_o(std_version_o), .serial_number_o(serial_number_o),
    .fw_version_o(fw_version_o), .mm_version_o(mm_version_o),
    .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // responder configuration (written by the stimulus only)
  logic [15:0] mem [0:15];
  logic [15:0] echo_val;
  logic        noack_en = 1'b0, delay_en = 1'b0, spur_wr = 1'b0;
  logic [3:0]  noack_addr = 4'h0, delay_addr = 4'h0;
  int          scan_id = 0;

  // monitor / responder state (written by the negedge process only)
  int          cyc = 0, seen_id = 0;
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, first_strobe = -1, viol = 0, log_n = 0;
  int          strobe_cyc [0:15];
  logic [3:0]  log_addr [0:15];
  logic        log_wr [0:15];
  logic        strobe_now = 1'b0, done_prev = 1'b0, rd_prev = 1'b0, wr_prev = 1'b0;
  logic        pending = 1'b0, pend_wr = 1'b0;
  logic [3:0]  held_addr = 4'h0, last_addr = 4'h0, r_addr = 4'h0;
  logic [15:0] held_data = 16'h0000, wr_data_seen = 16'h0000;
  logic        r_wr = 1'b0;
  int          phase = 0;

  always @(negedge clk) begin
    cyc++;
    if (scan_id != seen_id) begin
      seen_id = scan_id; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_strobe = -1;
      log_n = 0; pending = 1'b0; phase = 0;
      for (int a = 0; a < 16; a++) strobe_cyc[a] = -1;
    end
    if (!rst_n) pending = 1'b0;
    if (pending && ((pend_wr && bus.vme_wr_done_i) || (!pend_wr && bus.vme_rd_done_i))) pending = 1'b0;
    if (done_o) begin
      done_cnt++; done_cyc = cyc; pending = 1'b0;
      if (done_prev) viol++;
    end
    done_prev = done_o;
    if (pending && (bus.vme_addr_o != held_addr || bus.vme_wr_data_o != held_data)) viol++;
    if (bus.vme_rd_mem_o && bus.vme_wr_mem_o) viol++;
    if ((bus.vme_rd_mem_o && rd_prev) || (bus.vme_wr_mem_o && wr_prev)) viol++;
    rd_prev = bus.vme_rd_mem_o;
    wr_prev = bus.vme_wr_mem_o;
    strobe_now = bus.vme_rd_mem_o | bus.vme_wr_mem_o;
    // responder: done one cycle after the strobe, optionally delayed or withheld
    bus.vme_rd_done_i = 1'b0;
    bus.vme_wr_done_i = 1'b0;
    bus.vme_rd_data_i = 16'hDEAD;
    if (phase == 2) begin
      bus.vme_wr_done_i = spur_wr;
      phase = 1;
    end else if (phase == 1) begin
      if (r_wr) bus.vme_wr_done_i = 1'b1;
      else begin
        bus.vme_rd_done_i = 1'b1;
        bus.vme_rd_data_i = (r_addr == 4'hB) ? echo_val : mem[r_addr];
      end
      phase = 0;
    end
    if (strobe_now) begin
      if (first_strobe < 0) first_strobe = cyc;
      strobe_cyc[bus.vme_addr_o] = cyc;
      if (log_n < 16) begin
        log_addr[log_n] = bus.vme_addr_o; log_wr[log_n] = bus.vme_wr_mem_o; log_n++;
      end
      if (bus.vme_wr_mem_o) begin wr_cnt++; wr_data_seen = bus.vme_wr_data_o; end
      else rd_cnt++;
      pending = 1'b1; pend_wr = bus.vme_wr_mem_o;
      held_addr = bus.vme_addr_o; held_data = bus.vme_wr_data_o; last_addr = bus.vme_addr_o;
      r_addr = bus.vme_addr_o; r_wr = bus.vme_wr_mem_o;
      if (noack_en && bus.vme_addr_o == noack_addr) phase = 3;
      else if (delay_en && !r_wr && bus.vme_addr_o == delay_addr) phase = 2;
      else phase = 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_done(input int bound, input string tag);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin tick(1); k++; end
    chk(tag, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic start_scan();
    scan_id++;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, k, saved;
    logic found;
    rst_n = 1'b0; start_i = 1'b0;
    bus.vme_rd_done_i = 1'b0; bus.vme_wr_done_i = 1'b0; bus.vme_rd_data_i = 16'h0000;
    for (int a = 0; a < 16; a++) mem[a] = 16'h0000;
    mem[0] = 16'h0001; mem[1] = 16'h0000; mem[2] = 16'h0123; mem[3] = 16'h4567;
    mem[4] = 16'h89AB; mem[5] = 16'hCDEF; mem[6] = 16'h0002; mem[7] = 16'h0304;
    mem[8] = 16'h0001; mem[9] = 16'h0000; echo_val = 16'h00A5;
    tick(3);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_err", 64'(err_code_o), 64'd0);
    chk("rst_strobe", 64'(bus.vme_rd_mem_o | bus.vme_wr_mem_o), 64'd0);
    chk("rst_addr", 64'(bus.vme_addr_o), 64'd0);
    chk("rst_std", 64'(std_version_o), 64'd0);
    chk("rst_serial", serial_number_o, 64'd0);

    // nominal scan started automatically by reset release
    scan_id++;
    c0 = cyc;
    rst_n = 1'b1;
    wait_done(100, "nom_done_seen");
    chk("auto_start_cycle", 64'(first_strobe), 64'(c0 + 1));
    chk("nom_latency", 64'(done_cyc - first_strobe), 64'd25); // 24 transaction cycles + CHECK
    chk("nom_busy_at_done", 64'(busy_o), 64'd1);
    chk("nom_err", 64'(err_code_o), 64'd0);
    chk("nom_fw", 64'(fw_version_o), 64'h020304);
    chk("nom_mm", 64'(mm_version_o), 64'h010000);
    chk("nom_serial", serial_number_o, 64'h0123456789ABCDEF);
    chk("nom_std", 64'(std_version_o), 64'h00010000);
    chk("nom_rd_cnt", 64'(rd_cnt), 64'd11);
    chk("nom_wr_cnt", 64'(wr_cnt), 64'd1);
    chk("nom_wr_data", 64'(wr_data_seen), 64'h00A5);
    for (int i = 0; i < 12; i++) begin
      chk("order_addr", 64'(log_addr[i]), (i < 10) ? 64'(i) : 64'd11);
      chk("order_kind", 64'(log_wr[i]), 64'(i == 10));
    end
    tick(1);
    chk("nom_valid", 64'(valid_o), 64'd1);
    chk("nom_busy_after", 64'(busy_o), 64'd0);
    chk("nom_single_done", 64'(done_cnt), 64'd1);

    // spurious wr_done during a read WAIT, and start_i pulsed mid-scan
    mem[2] = 16'h2468; delay_en = 1'b1; delay_addr = 4'h2; spur_wr = 1'b1;
    start_scan();
    tick(6);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    wait_done(100, "spur_done_seen");
    chk("spur_latency", 64'(done_cyc - first_strobe), 64'd26);
    chk("spur_serial", serial_number_o, 64'h2468456789ABCDEF);
    chk("spur_err", 64'(err_code_o), 64'd0);
    tick(3);
    chk("midstart_rd_cnt", 64'(rd_cnt), 64'd11);
    chk("midstart_done_cnt", 64'(done_cnt), 64'd1);
    chk("spur_valid", 64'(valid_o), 64'd1);
    mem[2] = 16'h0123; delay_en = 1'b0; spur_wr = 1'b0;

    // standard version mismatch
    mem[0] = 16'h0002;
    start_scan();
    wait_done(50, "std_done_seen");
    chk("std_err", 64'(err_code_o), 64'd2);
    chk("std_rd_cnt", 64'(rd_cnt), 64'd1);
    chk("std_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("std_word", 64'(std_version_o), 64'h00020000);
    tick(1);
    chk("std_valid", 64'(valid_o), 64'd0);
    mem[0] = 16'h0001;

    // address 0x4 never acknowledged
    noack_en = 1'b1; noack_addr = 4'h4;
    start_scan();
    wait_done(400, "to_done_seen");
    chk("to_latency", 64'(done_cyc - strobe_cyc[4]), 64'(TIMEOUT));
    chk("to_err", 64'(err_code_o), 64'd1);
    chk("to_no_addr5", 64'(strobe_cyc[5]), 64'(-1));
    chk("to_rd_cnt", 64'(rd_cnt), 64'd5);
    tick(1);
    chk("to_valid", 64'(valid_o), 64'd0);
    noack_en = 1'b0;

    // echo readback mismatch, other fields still captured
    echo_val = 16'h005A; mem[6] = 16'h0009;
    start_scan();
    wait_done(100, "echo_done_seen");
    chk("echo_err", 64'(err_code_o), 64'd3);
    chk("echo_fw", 64'(fw_version_o), 64'h090304);
    chk("echo_serial", serial_number_o, 64'h0123456789ABCDEF);
    tick(1);
    chk("echo_valid", 64'(valid_o), 64'd0);
    echo_val = 16'h00A5; mem[6] = 16'h0002;

    // reset during the 0x3 WAIT with its done arriving the next cycle
    delay_en = 1'b1; delay_addr = 4'h3; spur_wr = 1'b0;
    start_scan();
    found = 1'b0; k = 0;
    while (!found && k < 40) begin
      tick(1); k++;
      if (strobe_now && last_addr == 4'h3) found = 1'b1;
    end
    chk("rr_found_addr3", 64'(found), 64'd1);
    tick(1);
    rst_n = 1'b0;
    saved = done_cnt;
    tick(1);
    rst_n = 1'b1;
    delay_en = 1'b0;
    chk("rr_busy", 64'(busy_o), 64'd0);
    chk("rr_std", 64'(std_version_o), 64'd0);
    chk("rr_serial", serial_number_o, 64'd0);
    chk("rr_err", 64'(err_code_o), 64'd0);
    chk("rr_addr", 64'(bus.vme_addr_o), 64'd0);
    tick(1);
    chk("rr_restart_strobe", 64'(strobe_now & bus.vme_rd_mem_o), 64'd1);
    chk("rr_restart_addr", 64'(bus.vme_addr_o), 64'd0);
    chk("rr_no_capture", serial_number_o, 64'd0);
    chk("rr_no_done", 64'(done_cnt), 64'(saved));
    wait_done(100, "rr_done_seen");
    chk("rr_final_err", 64'(err_code_o), 64'd0);
    chk("rr_fw", 64'(fw_version_o), 64'h020304);
    tick(1);
    chk("rr_valid", 64'(valid_o), 64'd1);
    chk("protocol_violations", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
